data_mem_ctrl: RTL and testbench

Data-memory responder for the Synapse32 core: the memory-side end of the load/store interface driven by the control unit. It accepts one request at a time (address, read/write strobe, RISC-V funct3 size code, store data), performs byte/half/word writes into an internal word array, and returns sign- or zero-extended load data. Each request ends with a one-cycle acknowledge and an error flag for misaligned, out-of-range or illegal requests.

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-side responder for the load/store interface.
// One request at a time; byte/half/word stores with lane enables, loads
// returned through a registered read and sign/zero extension, and a
// one-cycle ack (with err) closing every accepted request.
module data_mem_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_write,
  output logic [31:0] mem_read,
  output logic        ready,
  output logic        ack,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_reg;
  logic             err_pending_reg;
  logic [1:0]       lane_reg;
  logic [2:0]       funct3_reg;
  logic [31:0]      rd_word_reg;
  logic [31:0]      mem_read_reg;

  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             size_ok;
  logic             misalign;
  logic             range_bad;
  logic             illegal;
  logic             do_store;
  logic             do_load;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_val;

  assign ready    = (state_reg == IDLE);
  assign ack      = (state_reg == DONE);
  assign err      = ack & err_pending_reg;
  assign mem_read = mem_read_reg;

  // A request is only taken in IDLE and never while reset is asserted.
  assign accept    = rst & ready & (rd_en | wr_en);
  assign misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign range_bad = ({2'b00, addr[31:2]} >= 32'(DEPTH));
  assign illegal   = (rd_en & wr_en) | ~size_ok | misalign | range_bad;
  assign do_store  = accept & wr_en & ~illegal;
  assign do_load   = accept & rd_en & ~illegal;
  assign word_idx  = addr[IDX_W+1:2];

  // Size code legality: unsigned variants exist only for loads.
  always_comb begin
    size_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~wr_en;
      default:                size_ok = 1'b0;
    endcase
  end

  // Store data replicated across lanes so each enabled lane sees its slice.
  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata = {4{mem_write[7:0]}};
      2'b01:   wdata = {2{mem_write[15:0]}};
      default: wdata = mem_write;
    endcase
  end

  // Per-lane write enables (lane 0 = bits [7:0], little-endian).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = (funct3[1:0] == 2'b00) ? (addr[1:0] == 2'(gi)) :
                           (funct3[1:0] == 2'b01) ? (addr[1] == 1'(gi / 2)) :
                           1'b1;
    end
  endgenerate

  // Word array: lane-masked writes and registered read, no reset on contents.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (do_load) begin
      rd_word_reg <= mem[word_idx];
    end
  end

  // Lane/half selection and extension of the registered read word.
  always_comb begin
    sel_byte = rd_word_reg[{lane_reg, 3'b000} +: 8];
    sel_half = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    case (funct3_reg)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'h0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'h0, sel_half};
      default: load_val = rd_word_reg;
    endcase
  end

  // Request sequencing: IDLE -> (RD_WAIT) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      err_pending_reg <= 1'b0;
      lane_reg        <= 2'b00;
      funct3_reg      <= 3'b000;
      mem_read_reg    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_pending_reg <= 1'b1;
              state_reg       <= DONE;
              if (rd_en) begin
                mem_read_reg <= 32'h0;
              end
            end else if (rd_en) begin
              lane_reg   <= addr[1:0];
              funct3_reg <= funct3;
              state_reg  <= RD_WAIT;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        RD_WAIT: begin
          mem_read_reg <= load_val;
          state_reg    <= DONE;
        end
        DONE: begin
          err_pending_reg <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: table of requests with expected results,
// scoreboard queue popped on ack, plus hand sequences for busy and reset.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  funct3;
  logic [31:0] mem_write;
  logic [31:0] mem_read;
  logic        ready;
  logic        ack;
  logic        err;

  data_mem_ctrl #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .funct3(funct3), .mem_write(mem_write), .mem_read(mem_read),
    .ready(ready), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and check its completion against the scoreboard.
  task automatic run(input int idx, input vec_t v);
    int   lat;
    int   w;
    exp_t e;
    w = 0;
    while (!ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d ready", idx), 32'(ready), 32'd1);
    rd_en = v.rd; wr_en = v.wr; funct3 = v.f3; addr = v.a; mem_write = v.wd;
    sb.push_back('{v.exp_err, v.chk_rd, v.exp_rd,
                   (v.rd && !v.wr && !v.exp_err) ? 2 : 1});
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 6);
    chk($sformatf("v%0d ack_seen", idx), 32'(ack), 32'd1);
    e = sb.pop_front();
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(e.exp_lat));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(e.exp_err));
    if (e.chk_rd) chk($sformatf("v%0d mem_read", idx), mem_read, e.exp_rd);
    $display("v%0d rd=%0b wr=%0b f3=%03b addr=%08h wd=%08h -> lat=%0d err=%0b mem_read=%08h",
             idx, v.rd, v.wr, v.f3, v.a, v.wd, lat, err, mem_read);
    @(negedge clk);
    chk($sformatf("v%0d ack_single", idx), 32'(ack), 32'd0);
  endtask

  initial begin
    // rd, wr, f3, addr, wdata, exp_err, chk_rd, exp_rd
    vecs.push_back('{0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 1, 32'h00000000});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        0, 1, 32'hDEADBEEF});
    vecs.push_back('{0, 1, 3'b000, 32'h11,  32'h00000080, 0, 1, 32'hDEADBEEF});
    vecs.push_back('{1, 0, 3'b000, 32'h11,  32'h0,        0, 1, 32'hFFFFFF80});
    vecs.push_back('{1, 0, 3'b100, 32'h11,  32'h0,        0, 1, 32'h00000080});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        0, 1, 32'hDEAD80EF});
    vecs.push_back('{0, 1, 3'b001, 32'h12,  32'h00008001, 0, 1, 32'hDEAD80EF});
    vecs.push_back('{1, 0, 3'b001, 32'h12,  32'h0,        0, 1, 32'hFFFF8001});
    vecs.push_back('{1, 0, 3'b101, 32'h12,  32'h0,        0, 1, 32'h00008001});
    vecs.push_back('{1, 0, 3'b010, 32'h13,  32'h0,        1, 1, 32'h00000000});
    vecs.push_back('{0, 1, 3'b001, 32'h11,  32'h00001234, 1, 1, 32'h00000000});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        0, 1, 32'h800180EF});
    vecs.push_back('{0, 1, 3'b011, 32'h10,  32'h0,        1, 1, 32'h800180EF});
    vecs.push_back('{0, 1, 3'b010, 32'h1000, 32'h0,       1, 1, 32'h800180EF});
    vecs.push_back('{0, 1, 3'b101, 32'h10,  32'h0,        1, 1, 32'h800180EF});
    vecs.push_back('{1, 1, 3'b010, 32'h10,  32'h0,        1, 0, 32'h00000000});
    vecs.push_back('{1, 0, 3'b010, 32'h10,  32'h0,        0, 1, 32'h800180EF});
    vecs.push_back('{0, 1, 3'b010, 32'hFFC, 32'h11223344, 0, 1, 32'h800180EF});
    vecs.push_back('{1, 0, 3'b000, 32'hFFF, 32'h0,        0, 1, 32'h00000011});
    vecs.push_back('{1, 0, 3'b001, 32'hFFE, 32'h0,        0, 1, 32'h00001122});
    vecs.push_back('{1, 0, 3'b000, 32'hFFC, 32'h0,        0, 1, 32'h00000044});
    vecs.push_back('{1, 0, 3'b010, 32'hFFC, 32'h0,        0, 1, 32'h11223344});

    // Reset held for two cycles with a load strobe present.
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'b010;
    addr = 32'h10; mem_write = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_read", mem_read, 32'h0);
    rd_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("post_rst ack", 32'(ack), 32'd0);
    chk("post_rst ready", 32'(ready), 32'd1);
    $display("reset: ready=%0b ack=%0b err=%0b mem_read=%08h", ready, ack, err, mem_read);

    for (int i = 0; i < vecs.size(); i++) begin
      run(i, vecs[i]);
    end

    // Store strobe during RD_WAIT must be ignored.
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
    chk("busy ready_low", 32'(ready), 32'd0);
    chk("busy rdwait_ack", 32'(ack), 32'd0);
    wr_en = 1'b1; mem_write = 32'h0;
    @(negedge clk);
    chk("busy ack", 32'(ack), 32'd1);
    chk("busy mem_read", mem_read, 32'h800180EF);
    chk("busy done_ready", 32'(ready), 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    chk("busy no_extra_ack1", 32'(ack), 32'd0);
    @(negedge clk);
    chk("busy no_extra_ack2", 32'(ack), 32'd0);
    $display("busy: ignored store during RD_WAIT, mem_read=%08h", mem_read);
    run(100, '{1, 0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h800180EF});

    // Reset asserted in RD_WAIT aborts the load.
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'hFFC;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort ack", 32'(ack), 32'd0);
    chk("abort mem_read", mem_read, 32'h0);
    @(negedge clk);
    chk("abort no_late_ack", 32'(ack), 32'd0);
    $display("abort: ready=%0b ack=%0b mem_read=%08h", ready, ack, mem_read);
    run(101, '{1, 0, 3'b010, 32'hFFC, 32'h0, 0, 1, 32'h11223344});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
